irq_ctrl: RTL
=============

# irq_ctrl

Parametrised platform interrupt controller for the RV32 core. Replaces the fixed set of per-peripheral interrupt wires (GPIO, UART, timer) with NUM_SRC generic sources, each with its own priority, enable, and edge/level mode. It presents a single machine external interrupt request to the trap unit. Software services it through a claim/complete register interface on the DBus, using the same port style as the machine timer.

## Interface
Parameters:
- NUM_SRC, 10, number of interrupt sources, 1..31; source id = bit index + 1, id 0 = "none"
- PRIO_WIDTH, 3, priority field width, 1..4; priority 0 = never interrupts
- ADDR_WIDTH, 4, word-address width of register window

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- src_int  in  NUM_SRC  raw interrupt inputs, source id k on bit k-1
- rd_en  in  1  register read strobe (DBus)
- wr_en  in  1  register write strobe (DBus)
- addr  in  ADDR_WIDTH  word address
- wr_data  in  32  write data
- wr_strobe  in  4  byte write strobes
- rd_data  out  32  read data, combinational; 0 when rd_en=0
- irq  out  1  external interrupt request to trap unit
- irq_id  out  5  currently selected id, 0 if none (debug/trace)

## Operation
- Register map (word addresses); bit k of a mask register = source id k, bit 0 and bits >NUM_SRC read 0 and ignore writes:
  - 0x0 PENDING: RO for level sources; write-1-clear for edge sources.
  - 0x1 ENABLE: RW.
  - 0x2 MODE: RW, 1 = edge, 0 = level.
  - 0x3 THRESHOLD: RW, bits [PRIO_WIDTH-1:0].
  - 0x4 CLAIM: a read returns the selected id and claims it. A write completes id wr_data[4:0].
  - 0x8..0xB PRIORITY: 4-bit field per id. Word 0x8+(id>>3), bits [4*(id&7)+:4], upper bits beyond PRIO_WIDTH read 0.
  - Unmapped addresses read 0 and ignore writes.
- wr_strobe is honoured per byte on all RW registers. CLAIM complete requires wr_strobe[0].
- Gateway per source:
  - Level: pending set when input=1 and not pending and not in-service.
  - Edge: rising edge (input vs. previous sample) sets pending regardless of in-service. Multiple edges while pending coalesce to one.
- Selection: among sources with pending & enable & !in_service & prio>threshold, choose highest priority; ties go to lowest id. Result registered into irq_id.
- irq = (irq_id != 0).
- Claim (rd_en & addr==0x4):
  - rd_data = irq_id.
  - At the clock edge: pending[irq_id] cleared, in_service[irq_id] set.
  - If irq_id=0: returns 0, no state change.
  - Side effect occurs on every cycle the read is asserted; DBus asserts rd_en for exactly one cycle per access.
- Complete (wr_en & addr==0x4): clears in_service[id]. Ignored if id=0, id>NUM_SRC, or not in service.
- Simultaneous events:
  - Edge-source rising edge in the same cycle as its claim: pending remains 1, in_service set.
  - W1C and a new edge in the same cycle: set wins.
  - Claim and complete cannot coincide (single port).

## Timing
- Reset: all registers, pending, in_service, edge history, irq_id = 0; irq=0.
- src_int sampled at edge k → pending visible after edge k → irq_id/irq update after edge k+1. Latency is 2 cycles.
- Claim read at edge k → irq_id reflects new selection after edge k+1. irq may stay high one cycle after claim; the trap unit tolerates this because MIE is cleared on trap entry.
- Register writes take effect at the clock edge. Selection reflects them one cycle later.
- rst mid-operation: all state cleared the same edge; pending in-service sources are lost; level inputs still high re-pend 1 cycle after rst deasserts.

## Configuration
- IRQ_CTRL_SYNC_EN defined: each src_int passes a 2-flop synchroniser (reset 0) before the gateway. Latency becomes 4 cycles. Required for asynchronous GPIO-derived sources.
- Undefined: src_int used directly (same-clock sources only). Latency 2 cycles.

## Test plan
- Level basic: prio[3]=2, ENABLE=0x8, THRESHOLD=0, raise src_int[2] → irq=1 after 2 cycles, CLAIM reads 3, irq=0 within 2 cycles; complete 3 while input high → irq=1 again 2 cycles later.
- Priority/tie: prio[2]=5, prio[7]=5, prio[4]=6, all pending and enabled → successive claims return 4, 2, 7, then 0.
- Threshold/enable: prio[6]=3, THRESHOLD=3 → irq stays 0; THRESHOLD=2 → irq=1; clear ENABLE bit 6 → irq=0, PENDING bit 6 still 1.
- Edge mode: MODE bit 5=1; three 1-cycle pulses before claim → claim returns 5, next claim 0; pulse coincident with claim → PENDING bit 5 stays 1. W1C 0x20 clears it.
- Invalid complete: complete 0, 31, and a non-in-service id → in_service unchanged; unmapped read returns 0.
- Reset mid-service: claim 3, assert rst 1 cycle → PENDING/ENABLE/prio read 0, irq=0. With IRQ_CTRL_SYNC_EN, repeat the first scenario and require 4-cycle latency.

Source files
------------

// File: rtl/irq_ctrl.sv
// Platform interrupt controller: per-source gateways, priority selection, claim/complete register window.
// Define IRQ_CTRL_SYNC_EN to place a 2-flop synchroniser in front of every source input.
module irq_ctrl #(
    parameter int NUM_SRC    = 10,
    parameter int PRIO_WIDTH = 3,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_int,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strobe,
    output logic [31:0]           rd_data,
    output logic                  irq,
    output logic [4:0]            irq_id
);

    localparam logic [ADDR_WIDTH-1:0] A_PENDING = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_ENABLE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_MODE    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_THRESH  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_CLAIM   = ADDR_WIDTH'(4);

    // Priority fields are packed eight ids per word, one nibble each.
    function automatic logic [ADDR_WIDTH-1:0] prio_addr(input int id);
        return ADDR_WIDTH'(8 + (id >> 3));
    endfunction

    function automatic logic [4:0] prio_lsb(input int id);
        return 5'(4 * (id & 7));
    endfunction

    function automatic logic [1:0] prio_byte(input int id);
        return 2'((id & 7) >> 1);
    endfunction

    logic [NUM_SRC-1:0]    src;
    logic [NUM_SRC-1:0]    pending;
    logic [NUM_SRC-1:0]    in_service;
    logic [NUM_SRC-1:0]    prev;
    logic [NUM_SRC-1:0]    enable;
    logic [NUM_SRC-1:0]    mode;
    logic [PRIO_WIDTH-1:0] threshold;
    logic [PRIO_WIDTH-1:0] prio [NUM_SRC];

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_int;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = src_int;
`endif

    logic                  claim;
    logic                  complete;
    logic [NUM_SRC-1:0]    byte_en;
    logic [NUM_SRC-1:0]    wr_bits;
    logic [NUM_SRC-1:0]    claim_mask;
    logic [NUM_SRC-1:0]    done_mask;
    logic [NUM_SRC-1:0]    w1c_mask;
    logic [NUM_SRC-1:0]    set_mask;
    logic [4:0]            sel_id;
    logic [PRIO_WIDTH-1:0] sel_prio;
    logic                  unused_wr;

    assign claim    = rd_en && (addr == A_CLAIM) && (irq_id != 5'd0);
    assign complete = wr_en && (addr == A_CLAIM) && wr_strobe[0];
    assign wr_bits  = wr_data[NUM_SRC:1];
    assign unused_wr = ^wr_data;

    always_comb begin
        byte_en    = '0;
        claim_mask = '0;
        done_mask  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            byte_en[i]    = wr_strobe[2'((i + 1) >> 3)];
            claim_mask[i] = claim && (irq_id == 5'(i + 1));
            done_mask[i]  = complete && (wr_data[4:0] == 5'(i + 1));
        end
    end

    // Only edge sources are software-clearable; a new edge in the same cycle wins over the clear.
    assign w1c_mask = (wr_en && (addr == A_PENDING)) ? (mode & byte_en & wr_bits) : '0;
    assign set_mask = (mode & src & ~prev) | (~mode & src & ~pending & ~in_service);

    // Strictly-greater compare while scanning upward gives ties to the lowest id.
    always_comb begin
        sel_id   = '0;
        sel_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && !in_service[i] &&
                (prio[i] > threshold) && (prio[i] > sel_prio)) begin
                sel_id   = 5'(i + 1);
                sel_prio = prio[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
            prev       <= '0;
            enable     <= '0;
            mode       <= '0;
            threshold  <= '0;
            irq_id     <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
        end else begin
            pending    <= (pending & ~(claim_mask | w1c_mask)) | set_mask;
            in_service <= (in_service & ~done_mask) | claim_mask;
            prev       <= src;
            irq_id     <= sel_id;
            if (wr_en && (addr == A_ENABLE)) begin
                enable <= (enable & ~byte_en) | (wr_bits & byte_en);
            end
            if (wr_en && (addr == A_MODE)) begin
                mode <= (mode & ~byte_en) | (wr_bits & byte_en);
            end
            if (wr_en && (addr == A_THRESH) && wr_strobe[0]) begin
                threshold <= wr_data[PRIO_WIDTH-1:0];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (wr_en && (addr == prio_addr(i + 1)) && wr_strobe[prio_byte(i + 1)]) begin
                    prio[i] <= wr_data[prio_lsb(i + 1) +: PRIO_WIDTH];
                end
            end
        end
    end

    assign irq = (irq_id != 5'd0);

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            if (addr == A_PENDING) begin
                rd_data[NUM_SRC:1] = pending;
            end else if (addr == A_ENABLE) begin
                rd_data[NUM_SRC:1] = enable;
            end else if (addr == A_MODE) begin
                rd_data[NUM_SRC:1] = mode;
            end else if (addr == A_THRESH) begin
                rd_data[PRIO_WIDTH-1:0] = threshold;
            end else if (addr == A_CLAIM) begin
                rd_data[4:0] = irq_id;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (addr == prio_addr(i + 1)) begin
                        rd_data[prio_lsb(i + 1) +: PRIO_WIDTH] = prio[i];
                    end
                end
            end
        end
    end

endmodule
